// File: rtl/xor_edge_logger.sv
// ---------------------------------------------------------------------------
// xor_edge_logger
//   Watches the output Q of a 2-input XOR cell. Q is asynchronous to clk, so
//   it is first brought into the clock domain. Each rising or falling
//   transition is then stamped with a free-running cycle counter. The
//   resulting records wait in a small first-word-fall-through FIFO and are
//   drained over a valid/ready port.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   q_in       in   1      XOR cell output, asynchronous to clk
//   en         in   1      1 = log edges, 0 = ignore edges (FIFO still drains)
//   q_sync     out  1      synchronised q_in (last synchroniser stage)
//   evt_valid  out  1      FIFO non-empty, record presented
//   evt_ready  in   1      consumer takes the record this cycle
//   evt_edge   out  1      1 = rising, 0 = falling
//   evt_time   out  TS_W   timestamp of the detection cycle
//   edge_cnt   out  CNT_W  accepted edges, wraps
//   drop_cnt   out  CNT_W  edges lost to a full FIFO, saturates
//   overflow   out  1      sticky drop flag, cleared only by rst
// ---------------------------------------------------------------------------
module xor_edge_logger #(
  parameter int SYNC_STAGES = 2,
  parameter int TS_W        = 16,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             en,
  output logic             q_sync,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_edge,
  output logic [TS_W-1:0]  evt_time,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_W + 1;

  // -------------------------------------------------------------------------
  // Synchroniser and previous-value register
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   q_prev_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], q_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      q_prev_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      // Tracked regardless of en, so enabling logging never sees a stale
      // value and never invents an edge.
      q_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_sync = sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Free-running timestamp
  // -------------------------------------------------------------------------
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] ts_d;

  assign ts_d = ts_q + TS_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  // -------------------------------------------------------------------------
  // Edge detect and FIFO control
  // -------------------------------------------------------------------------
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        empty;
  logic        full;
  logic        det;
  logic        pop;
  logic        push;
  logic        drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign det   = en & (q_sync != q_prev_q);
  assign pop   = !empty & evt_ready;
  // A full FIFO that is being popped this cycle frees the slot in time.
  assign push  = det & (!full | pop);
  assign drop  = det & full & !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Record storage: {edge, timestamp}. Contents need no reset; reads are
  // masked while the FIFO is empty.
  // -------------------------------------------------------------------------
  logic [RW-1:0] mem_q [DEPTH];
  logic [RW-1:0] wr_rec;
  logic [RW-1:0] rd_rec;

  assign wr_rec = {q_sync, ts_q};

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_rec;
    end
  end

  assign rd_rec    = mem_q[rd_ptr_q[AW-1:0]];
  assign evt_valid = !empty;
  assign evt_edge  = evt_valid ? rd_rec[TS_W]     : 1'b0;
  assign evt_time  = evt_valid ? rd_rec[TS_W-1:0] : '0;

  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (push) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {CNT_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;

endmodule
